// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned BIN_W_DEF  = 32;
    localparam int unsigned DIGITS_DEF = 8;

    // Iteration counter width for a given input width.
    function automatic int cnt_width(input int unsigned bin_w);
        return (bin_w > 1) ? $clog2(bin_w) : 1;
    endfunction

    // Largest value representable in the given number of BCD digits (10^digits - 1).
    function automatic logic [63:0] max_value(input int unsigned digits);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < digits; i++) r = r * 64'd10;
        return r - 64'd1;
    endfunction

    // Packed BCD pattern with every digit set to 9.
    function automatic logic [63:0] all_nines(input int unsigned digits);
        logic [63:0] r;
        r = 64'd0;
        for (int unsigned i = 0; i < digits; i++) r = (r << 4) | 64'h9;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adj_c
);

    assign adj_c = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// Optional BIN2BCD_OVF_SAT_EN: saturate bcd_out to all nines on overflow.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = BIN_W_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      in_bin,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  done,
    output logic                  ovf
);

    localparam int unsigned BW    = 4 * DIGITS;
    localparam int unsigned CNT_W = cnt_width(BIN_W);
    localparam logic [63:0] MAX_VAL = max_value(DIGITS);
`ifdef BIN2BCD_OVF_SAT_EN
    localparam logic [BW-1:0] ALL_NINES = BW'(all_nines(DIGITS));
`endif

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BW-1:0]      work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [BW-1:0]      bcd_d;
    logic               done_d, ovf_d, ready_d;

    logic [BW-1:0]      work_adj;
    logic [BW-1:0]      work_shift;
    logic               unused_top;

    // Per-digit add-3 correction ahead of the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (work_q[4*g +: 4]),
            .adj_c (work_adj[4*g +: 4])
        );
    end

    // Top work bit falls off: it represents 10^DIGITS, giving a mod-10^DIGITS result.
    assign work_shift = {work_adj[BW-2:0], shift_q[BIN_W-1]};
    assign unused_top = work_adj[BW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_out    <= '0;
            done       <= 1'b0;
            ovf        <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_out    <= bcd_d;
            done       <= done_d;
            ovf        <= ovf_d;
            in_ready   <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_out;
        done_d     = 1'b0;
        ovf_d      = ovf;
        ready_d    = in_ready;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shift_d    = in_bin;
                    work_d     = '0;
                    cnt_d      = '0;
                    ovf_pend_d = 64'(in_bin) > MAX_VAL;
                    ready_d    = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                work_d  = work_shift;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
`ifdef BIN2BCD_OVF_SAT_EN
                    bcd_d = ovf_pend_q ? ALL_NINES : work_shift;
`else
                    bcd_d = work_shift;
`endif
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    ovf_d   = ovf_pend_q;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

endmodule
